// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the EX-stage data port.
// Optional fetch anti-starvation guard is compiled in when ARB_FAIR_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_r_ena_i,
    input  logic [31:0] d_r_addr_i,
    input  logic        d_w_ena_i,
    input  logic [31:0] d_w_addr_i,
    input  logic [31:0] d_w_data_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        ram_en_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    output logic        hold_o
);
    typedef enum logic {IDLE, RD_WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_D} own_t;

    localparam logic [2:0] LAT3 = 3'(RAM_LAT);

    if (RAM_LAT < 1 || RAM_LAT > 4 || STARVE_MAX < 1) begin : g_param_check
        $error("mem_port_arbiter: RAM_LAT must be 1..4 and STARVE_MAX at least 1");
    end

    state_t      r_state;
    own_t        r_own;
    logic [2:0]  r_cnt;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic w_rvalid_cyc;
    logic w_arb;
    logic w_fetch_first;
    logic w_gnt_w;
    logic w_gnt_dr;
    logic w_gnt_if;
    logic w_gnt_rd;

    // The rvalid cycle of a read doubles as an arbitration slot for back-to-back issue.
    assign w_rvalid_cyc = (r_state == RD_WAIT) && (r_cnt == 3'd1);
    assign w_arb        = !arst && ((r_state == IDLE) || w_rvalid_cyc);

    assign w_gnt_w  = w_arb && d_w_ena_i && !w_fetch_first;
    assign w_gnt_dr = w_arb && d_r_ena_i && !d_w_ena_i && !w_fetch_first;
    assign w_gnt_if = w_arb && if_req_i && (w_fetch_first || (!d_w_ena_i && !d_r_ena_i));
    assign w_gnt_rd = w_gnt_dr || w_gnt_if;

    assign if_gnt_o    = w_gnt_if;
    assign d_gnt_o     = w_gnt_w || w_gnt_dr;
    assign ram_en_o    = w_gnt_w || w_gnt_rd;
    assign ram_we_o    = w_gnt_w;
    assign ram_addr_o  = w_gnt_w  ? d_w_addr_i :
                         w_gnt_dr ? d_r_addr_i :
                         w_gnt_if ? if_addr_i  : '0;
    assign ram_wdata_o = w_gnt_w ? d_w_data_i : '0;

    assign if_rvalid_o = w_rvalid_cyc && (r_own == OWN_IF);
    assign d_rvalid_o  = w_rvalid_cyc && (r_own == OWN_D);
    assign if_rdata_o  = if_rvalid_o ? ram_rdata_i : r_if_rdata;
    assign d_rdata_o   = d_rvalid_o  ? ram_rdata_i : r_d_rdata;

    assign hold_o = !arst && ((if_req_i && !w_gnt_if) ||
                              (d_r_ena_i && !w_gnt_dr) ||
                              (d_w_ena_i && !w_gnt_w) ||
                              ((r_state == RD_WAIT) && !w_rvalid_cyc));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state    <= IDLE;
            r_own      <= OWN_IF;
            r_cnt      <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (if_rvalid_o) r_if_rdata <= ram_rdata_i;
            if (d_rvalid_o)  r_d_rdata  <= ram_rdata_i;
            if (w_gnt_rd) begin
                r_state <= RD_WAIT;
                r_cnt   <= LAT3;
                r_own   <= w_gnt_if ? OWN_IF : OWN_D;
            end else if (r_state == RD_WAIT) begin
                if (w_rvalid_cyc) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt - 3'd1;
                end
            end
        end
    end

`ifdef ARB_FAIR_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] r_starve;

    assign w_fetch_first = if_req_i && (r_starve >= SW'(STARVE_MAX));

    // Counts data grants taken while fetch waits; saturates at the threshold.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_starve <= '0;
        end else if (!if_req_i || w_gnt_if) begin
            r_starve <= '0;
        end else if ((w_gnt_w || w_gnt_dr) && (r_starve < SW'(STARVE_MAX))) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign w_fetch_first = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table for single-cycle arbitration,
// hand sequences for latency, back-to-back, reset-mid-read and starvation behaviour.
module tb_mem_port_arbiter;
    localparam int unsigned LAT  = 2;
    localparam int unsigned SMAX = 4;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arst;
    logic        if_req_i, d_r_ena_i, d_w_ena_i;
    logic [31:0] if_addr_i, d_r_addr_i, d_w_addr_i, d_w_data_i;
    logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
    logic [31:0] if_rdata_o, d_rdata_o;
    logic        ram_en_o, ram_we_o, hold_o;
    logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RAM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .arst(arst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_r_ena_i(d_r_ena_i), .d_r_addr_i(d_r_addr_i),
        .d_w_ena_i(d_w_ena_i), .d_w_addr_i(d_w_addr_i), .d_w_data_i(d_w_data_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .hold_o(hold_o)
    );

    // RAM model: data appears LAT cycles after the address cycle.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] rpipe   [LAT];
    assign ram_rdata_i = rpipe[LAT-1];

    always @(posedge clk) begin
        if (ram_en_o && ram_we_o) mem[ram_addr_o[9:2]] <= ram_wdata_o;
        rpipe[0] <= (ram_en_o && !ram_we_o) ? mem[ram_addr_o[9:2]] : 32'h0BAD_0000;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: read data expected per requester, popped on rvalid.
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic [31:0] mon_exp;

    always @(negedge clk) begin
        if (if_rvalid_o) begin
            if (if_q.size() == 0) begin
                chk("if_rvalid_unexpected", 32'(if_rvalid_o), 32'd0);
            end else begin
                mon_exp = if_q.pop_front();
                chk("if_rdata", if_rdata_o, mon_exp);
            end
        end
        if (d_rvalid_o) begin
            if (d_q.size() == 0) begin
                chk("d_rvalid_unexpected", 32'(d_rvalid_o), 32'd0);
            end else begin
                mon_exp = d_q.pop_front();
                chk("d_rdata", d_rdata_o, mon_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if_req_i  = 1'b0;
        d_r_ena_i = 1'b0;
        d_w_ena_i = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".if_gnt"},    32'(if_gnt_o),    32'd0);
        chk({tag, ".d_gnt"},     32'(d_gnt_o),     32'd0);
        chk({tag, ".if_rvalid"}, 32'(if_rvalid_o), 32'd0);
        chk({tag, ".d_rvalid"},  32'(d_rvalid_o),  32'd0);
        chk({tag, ".ram_en"},    32'(ram_en_o),    32'd0);
        chk({tag, ".ram_we"},    32'(ram_we_o),    32'd0);
        chk({tag, ".ram_addr"},  ram_addr_o,       32'd0);
        chk({tag, ".ram_wdata"}, ram_wdata_o,      32'd0);
        chk({tag, ".hold"},      32'(hold_o),      32'd0);
        chk({tag, ".if_rdata"},  if_rdata_o,       32'd0);
        chk({tag, ".d_rdata"},   d_rdata_o,        32'd0);
    endtask

    task automatic fetch_read(input string tag, input logic [31:0] addr);
        if_req_i  = 1'b1;
        if_addr_i = addr;
        @(negedge clk);
        chk({tag, ".if_gnt"},   32'(if_gnt_o), 32'd1);
        chk({tag, ".ram_addr"}, ram_addr_o,    addr);
        if_q.push_back(ref_mem[addr[9:2]]);
        step();
        idle_all();
        repeat (LAT + 1) step();
    endtask

    typedef struct {
        logic        req_if, req_dr, req_dw;
        logic [31:0] a_if, a_dr, a_dw, wdata;
        logic        e_if_gnt, e_d_gnt, e_en, e_we, e_hold;
        logic [31:0] e_addr;
        int          e_own;
    } vec_t;

    vec_t vt [8];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        bit exp_if;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i * 4 + 3);
            ref_mem[i] = 32'(i * 4 + 3);
        end
        for (int i = 0; i < LAT; i++) rpipe[i] = '0;
        arst = 1'b1;
        idle_all();
        if_addr_i = '0; d_r_addr_i = '0; d_w_addr_i = '0; d_w_data_i = '0;

        //              req if dr dw   a_if    a_dr    a_dw    wdata           ifg dg en we hold addr     own
        vt[0] = '{1, 0, 0, 32'h10, 32'h0,  32'h0,  32'h0,          1, 0, 1, 0, 0, 32'h10, 1};
        vt[1] = '{0, 1, 0, 32'h0,  32'h20, 32'h0,  32'h0,          0, 1, 1, 0, 0, 32'h20, 2};
        vt[2] = '{0, 0, 1, 32'h0,  32'h0,  32'h40, 32'h1111_2222,  0, 1, 1, 1, 0, 32'h40, 0};
        vt[3] = '{1, 1, 0, 32'h14, 32'h24, 32'h0,  32'h0,          0, 1, 1, 0, 1, 32'h24, 2};
        vt[4] = '{0, 1, 1, 32'h0,  32'h84, 32'h80, 32'hCAFE_0001,  0, 1, 1, 1, 1, 32'h80, 0};
        vt[5] = '{1, 1, 1, 32'h18, 32'h28, 32'h44, 32'h0BAD_F00D,  0, 1, 1, 1, 1, 32'h44, 0};
        vt[6] = '{0, 0, 0, 32'h0,  32'h0,  32'h0,  32'h0,          0, 0, 0, 0, 0, 32'h0,  0};
        vt[7] = '{1, 0, 0, 32'h40, 32'h0,  32'h0,  32'h0,          1, 0, 1, 0, 0, 32'h40, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        step();
        arst = 1'b0;
        step();

        foreach (vt[i]) begin
            if_req_i   = vt[i].req_if; if_addr_i  = vt[i].a_if;
            d_r_ena_i  = vt[i].req_dr; d_r_addr_i = vt[i].a_dr;
            d_w_ena_i  = vt[i].req_dw; d_w_addr_i = vt[i].a_dw; d_w_data_i = vt[i].wdata;
            @(negedge clk);
            chk($sformatf("vec%0d.if_gnt", i),   32'(if_gnt_o), 32'(vt[i].e_if_gnt));
            chk($sformatf("vec%0d.d_gnt", i),    32'(d_gnt_o),  32'(vt[i].e_d_gnt));
            chk($sformatf("vec%0d.ram_en", i),   32'(ram_en_o), 32'(vt[i].e_en));
            chk($sformatf("vec%0d.ram_we", i),   32'(ram_we_o), 32'(vt[i].e_we));
            chk($sformatf("vec%0d.hold", i),     32'(hold_o),   32'(vt[i].e_hold));
            chk($sformatf("vec%0d.ram_addr", i), ram_addr_o,    vt[i].e_addr);
            if (vt[i].e_we) begin
                chk($sformatf("vec%0d.ram_wdata", i), ram_wdata_o, vt[i].wdata);
                ref_mem[vt[i].a_dw[9:2]] = vt[i].wdata;
            end
            if (vt[i].e_own == 1) if_q.push_back(ref_mem[vt[i].a_if[9:2]]);
            if (vt[i].e_own == 2) d_q.push_back(ref_mem[vt[i].a_dr[9:2]]);
            step();
            idle_all();
            repeat (LAT + 1) step();
        end

        // Fetch and data read together: data wins, fetch granted in the rvalid cycle.
        if_req_i = 1'b1; if_addr_i = 32'h18;
        d_r_ena_i = 1'b1; d_r_addr_i = 32'h28;
        @(negedge clk);
        chk("s1.T.d_gnt", 32'(d_gnt_o), 32'd1);
        chk("s1.T.if_gnt", 32'(if_gnt_o), 32'd0);
        chk("s1.T.hold", 32'(hold_o), 32'd1);
        d_q.push_back(ref_mem[32'h28 >> 2]);
        step();
        d_r_ena_i = 1'b0;
        @(negedge clk);
        chk("s1.T1.ram_en", 32'(ram_en_o), 32'd0);
        chk("s1.T1.hold", 32'(hold_o), 32'd1);
        step();
        @(negedge clk);
        chk("s1.T2.d_rvalid", 32'(d_rvalid_o), 32'd1);
        chk("s1.T2.if_gnt", 32'(if_gnt_o), 32'd1);
        chk("s1.T2.ram_addr", ram_addr_o, 32'h18);
        chk("s1.T2.hold", 32'(hold_o), 32'd0);
        if_q.push_back(ref_mem[32'h18 >> 2]);
        step();
        idle_all();
        @(negedge clk);
        chk("s1.T3.hold", 32'(hold_o), 32'd1);
        step();
        @(negedge clk);
        chk("s1.T4.if_rvalid", 32'(if_rvalid_o), 32'd1);
        chk("s1.T4.d_rdata_held", d_rdata_o, ref_mem[32'h28 >> 2]);
        chk("s1.T4.hold", 32'(hold_o), 32'd0);
        step();
        repeat (LAT) step();

        // Write and read together: write first, read the following cycle.
        d_w_ena_i = 1'b1; d_w_addr_i = 32'h100; d_w_data_i = 32'hDEAD_BEEF;
        d_r_ena_i = 1'b1; d_r_addr_i = 32'h104;
        @(negedge clk);
        chk("s2.T.ram_we", 32'(ram_we_o), 32'd1);
        chk("s2.T.ram_addr", ram_addr_o, 32'h100);
        chk("s2.T.ram_wdata", ram_wdata_o, 32'hDEAD_BEEF);
        chk("s2.T.hold", 32'(hold_o), 32'd1);
        ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        step();
        d_w_ena_i = 1'b0;
        @(negedge clk);
        chk("s2.T1.d_gnt", 32'(d_gnt_o), 32'd1);
        chk("s2.T1.ram_we", 32'(ram_we_o), 32'd0);
        chk("s2.T1.ram_addr", ram_addr_o, 32'h104);
        d_q.push_back(ref_mem[32'h104 >> 2]);
        step();
        idle_all();
        repeat (LAT + 1) step();
        fetch_read("s2.rb", 32'h100);

        // Write held off during RD_WAIT, granted in the rvalid cycle.
        d_r_ena_i = 1'b1; d_r_addr_i = 32'h30;
        @(negedge clk);
        chk("s3.T.d_gnt", 32'(d_gnt_o), 32'd1);
        d_q.push_back(ref_mem[32'h30 >> 2]);
        step();
        d_r_ena_i = 1'b0;
        d_w_ena_i = 1'b1; d_w_addr_i = 32'h34; d_w_data_i = 32'h3434_5656;
        @(negedge clk);
        chk("s3.T1.d_gnt", 32'(d_gnt_o), 32'd0);
        chk("s3.T1.ram_en", 32'(ram_en_o), 32'd0);
        chk("s3.T1.hold", 32'(hold_o), 32'd1);
        step();
        @(negedge clk);
        chk("s3.T2.d_rvalid", 32'(d_rvalid_o), 32'd1);
        chk("s3.T2.d_gnt", 32'(d_gnt_o), 32'd1);
        chk("s3.T2.ram_we", 32'(ram_we_o), 32'd1);
        chk("s3.T2.ram_addr", ram_addr_o, 32'h34);
        ref_mem[32'h34 >> 2] = 32'h3434_5656;
        step();
        idle_all();
        repeat (LAT + 1) step();
        fetch_read("s3.rb", 32'h34);

        // Back-to-back fetches 0x0, 0x4, 0x8.
        if_req_i = 1'b1; if_addr_i = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("s4.k%0d.if_gnt", k), 32'(if_gnt_o), 32'd1);
            chk($sformatf("s4.k%0d.ram_addr", k), ram_addr_o, 32'(k * 4));
            chk($sformatf("s4.k%0d.hold", k), 32'(hold_o), 32'd0);
            if (k > 0) chk($sformatf("s4.k%0d.if_rvalid", k), 32'(if_rvalid_o), 32'd1);
            if_q.push_back(ref_mem[k]);
            step();
            if (k < 2) if_addr_i = 32'((k + 1) * 4);
            else       if_req_i  = 1'b0;
            @(negedge clk);
            chk($sformatf("s4.k%0d.gap_gnt", k), 32'(if_gnt_o), 32'd0);
            chk($sformatf("s4.k%0d.gap_hold", k), 32'(hold_o), 32'd1);
            step();
        end
        @(negedge clk);
        chk("s4.last.if_rvalid", 32'(if_rvalid_o), 32'd1);
        step();
        repeat (LAT) step();

        // Reset mid-read: outstanding read is discarded.
        d_r_ena_i = 1'b1; d_r_addr_i = 32'h50;
        @(negedge clk);
        chk("s5.T.d_gnt", 32'(d_gnt_o), 32'd1);
        step();
        idle_all();
        arst = 1'b1;
        @(negedge clk);
        chk_zero("s5.rst");
        step();
        @(negedge clk);
        chk("s5.T2.d_rvalid", 32'(d_rvalid_o), 32'd0);
        step();
        arst = 1'b0;
        repeat (LAT + 1) step();
        fetch_read("s5.after", 32'h10);

        // Continuous writes with a pending fetch.
        if_req_i  = 1'b1; if_addr_i  = 32'h10;
        d_w_ena_i = 1'b1; d_w_addr_i = 32'h60; d_w_data_i = 32'h6060_6060;
        for (int k = 0; k < (FAIR ? SMAX + 1 : 8); k++) begin
            exp_if = FAIR && (k == SMAX);
            @(negedge clk);
            chk($sformatf("s6.k%0d.if_gnt", k), 32'(if_gnt_o), 32'(exp_if));
            chk($sformatf("s6.k%0d.d_gnt", k), 32'(d_gnt_o), 32'(!exp_if));
            chk($sformatf("s6.k%0d.hold", k), 32'(hold_o), 32'd1);
            if (exp_if) if_q.push_back(ref_mem[32'h10 >> 2]);
            else        ref_mem[32'h60 >> 2] = 32'h6060_6060;
            step();
        end
        idle_all();
        repeat (LAT + 2) step();
        fetch_read("s6.rb", 32'h60);

        @(negedge clk);
        chk("end.if_q_empty", 32'(if_q.size()), 32'd0);
        chk("end.d_q_empty", 32'(d_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port synchronous RAM between the instruction-fetch requester and the EX-stage data requester (load read port plus store write port). Accepts one transaction at a time, tracks the outstanding read through a configurable RAM read latency, and returns read data to the owning requester. Drives a hold request to the pipeline controller while any requester waits. Sits between IF/EX and the memory macro.

## Interface
- RAM_LAT, 1: RAM read latency in cycles from address-cycle to data-valid; legal range 1..4.
- STARVE_MAX, 4: consecutive data grants tolerated while fetch waits (used only with ARB_FAIR_EN).
- clk  in  1  clock, all state updates on rising edge.
- arst  in  1  asynchronous, active-high reset.
- if_req_i  in  1  fetch read request; held until granted.
- if_addr_i  in  32  fetch address.
- if_gnt_o  out  1  fetch accepted this cycle.
- if_rvalid_o  out  1  fetch data valid, one-cycle pulse.
- if_rdata_o  out  32  fetch data.
- d_r_ena_i  in  1  data read request; held until granted.
- d_r_addr_i  in  32  data read address.
- d_w_ena_i  in  1  data write request; held until granted.
- d_w_addr_i  in  32  data write address.
- d_w_data_i  in  32  data write value.
- d_gnt_o  out  1  data request (read or write) accepted this cycle.
- d_rvalid_o  out  1  data read value valid, one-cycle pulse.
- d_rdata_o  out  32  data read value.
- ram_en_o  out  1  RAM access strobe.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  32  RAM address.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data, valid RAM_LAT cycles after address cycle.
- hold_o  out  1  stall request to pipeline controller.

## Operation
- States: IDLE, RD_WAIT. Read owner flag OWN ∈ {IF, D} registered at grant.
- Arbitration happens in IDLE, or in RD_WAIT during the rvalid cycle (back-to-back). Grant and RAM strobe are combinational from requests in that cycle.
- Priority: data write > data read > fetch. Simultaneous d_w_ena_i and d_r_ena_i: write granted, read stays pending.
- Write grant: ram_en_o=1, ram_we_o=1, addr/data from d_w_*; d_gnt_o=1; completes in that cycle; state stays/returns IDLE; no rvalid.
- Read grant: ram_en_o=1, ram_we_o=0, addr from winner; gnt to winner; latency counter loaded with RAM_LAT; state -> RD_WAIT; OWN recorded.
- RD_WAIT: counter decrements each cycle; at counter==1 the owner’s rvalid pulses with rdata = ram_rdata_i (combinational pass-through); state -> IDLE unless a new read granted that cycle.
- Non-owner rdata outputs hold last delivered value; non-owner rvalid 0.
- hold_o = any request asserted and not granted this cycle, OR RD_WAIT and not rvalid cycle.
- Requests dropped before grant: no effect. Address changes while pending: value at grant cycle used.
- Reset (any time, including mid-read): state IDLE, counter 0, outstanding read discarded (no rvalid after release), all outputs 0, rdata registers 0, starvation counter 0.

## Timing
- Read grant cycle T -> rvalid at T+RAM_LAT; next grant possible at T+RAM_LAT. Peak read throughput 1 per RAM_LAT cycles; RAM_LAT=1 gives 1 read/cycle.
- Write: accepted and performed in grant cycle; a write may be granted in the rvalid cycle of a prior read.
- No grant in RD_WAIT before rvalid cycle; ram_en_o=0 there.
- Counter width 3 bits; never wraps (loaded ≤4, stops at 0).

## Configuration
- ARB_FAIR_EN defined: starvation counter increments on each data grant while if_req_i pending ungranted, clears on fetch grant or if_req_i low; at STARVE_MAX the next arbitration grants fetch over data (data held, hold_o=1).
- ARB_FAIR_EN undefined: strict fixed priority; fetch may starve indefinitely; counter logic absent.

## Test plan
- RAM_LAT=1, fetch only at 0x0000_0010, RAM returns 0x0000_0013 -> if_gnt_o at T, if_rvalid_o at T+1, if_rdata_o=0x0000_0013, hold_o=0 throughout.
- RAM_LAT=3, fetch and data read simultaneous -> d_gnt_o at T, d_rvalid_o at T+3, if_gnt_o at T+3, if_rvalid_o at T+6; hold_o=1 T..T+5 except cycles where nothing waits.
- Write 0xDEAD_BEEF to 0x100 with concurrent data read of 0x104 -> T: ram_we_o=1 addr 0x100; T+1: read granted addr 0x104.
- RAM_LAT=2, assert arst at T+1 after read grant -> no rvalid at T+2, all outputs 0, next request granted normally after release.
- ARB_FAIR_EN, STARVE_MAX=4, continuous data writes plus fetch -> fetch granted on 5th arbitration; without macro, fetch never granted while writes persist.
- Back-to-back fetches RAM_LAT=2 at 0x0,0x4,0x8 -> grants at T, T+2, T+4, rvalids at T+2, T+4, T+6 in order.
